// File: rtl/pe_array_sequencer.sv
// ---------------------------------------------------------------------------
// pe_array_sequencer
//
// Job-level sequencer that sits between the host/DMA command path and the
// PE-array control FSM. It accepts one convolution job per valid/ready
// handshake. It then drives the control block's rst/load/ready/start_op
// inputs in the required order, and it generates the weight-fetch address
// stream during the load phase.
//
// Ports:
//   clk_i, rst_i            clock (rising edge) and synchronous active-high reset
//   cmd_valid_i/ready_o     job command handshake
//   cmd_column_num_i        active columns of the job
//   cmd_f_sel_i             filter select of the job
//   cmd_en_adder_1/2_i      adder enables of the job
//   cmd_load_cycles_i       load-phase length (0 behaves as 1)
//   cmd_run_cycles_i        run-phase length (0 behaves as 1)
//   abort_i                 terminate the current job
//   ctl_rst/load/ready/start_op_o   control FSM inputs
//   column_num_o, f_sel_o, en_adder_1/2_o   latched job fields
//   wgt_rd_en_o, wgt_rd_addr_o  weight-buffer read port
//   run_cnt_o               elapsed run cycles of the current job
//   busy_o                  job in progress
//   done_o, aborted_o       one-cycle completion pulses
// ---------------------------------------------------------------------------
module pe_array_sequencer #(
  parameter int N             = 3,
  parameter int NUM_COL_WIDTH = $clog2(N),
  parameter int SEL_WIDTH     = $clog2(N),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [NUM_COL_WIDTH-1:0] cmd_column_num_i,
  input  logic [SEL_WIDTH-1:0]     cmd_f_sel_i,
  input  logic                     cmd_en_adder_1_i,
  input  logic                     cmd_en_adder_2_i,
  input  logic [CNT_WIDTH-1:0]     cmd_load_cycles_i,
  input  logic [CNT_WIDTH-1:0]     cmd_run_cycles_i,
  input  logic                     abort_i,
  output logic                     ctl_rst_o,
  output logic                     ctl_load_o,
  output logic                     ctl_ready_o,
  output logic                     ctl_start_op_o,
  output logic [NUM_COL_WIDTH-1:0] column_num_o,
  output logic [SEL_WIDTH-1:0]     f_sel_o,
  output logic                     en_adder_1_o,
  output logic                     en_adder_2_o,
  output logic                     wgt_rd_en_o,
  output logic [CNT_WIDTH-1:0]     wgt_rd_addr_o,
  output logic [CNT_WIDTH-1:0]     run_cnt_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_FIN,
    S_ABT
  } stateT;

  stateT r_state;
  stateT w_nextState;

  logic [CNT_WIDTH-1:0]     r_loadLen;
  logic [CNT_WIDTH-1:0]     r_runLen;
  logic [CNT_WIDTH-1:0]     r_addr;
  logic [CNT_WIDTH-1:0]     r_runCnt;
  logic [NUM_COL_WIDTH-1:0] r_columnNum;
  logic [SEL_WIDTH-1:0]     r_fSel;
  logic                     r_enAdder1;
  logic                     r_enAdder2;

  logic w_accept;
  logic w_loadLast;
  logic w_runLast;

  // A job is accepted only while idle; cmd_ready_o is itself a pure decode
  // of the IDLE state. The "last cycle" flags compare against the stored
  // length minus one over the full counter width. Because a stored length is
  // never zero, the subtraction cannot wrap, and a maximum-length job runs to
  // completion.
  assign w_accept   = (r_state == S_IDLE) && cmd_valid_i;
  assign w_loadLast = (r_addr == (r_loadLen - CNT_WIDTH'(1)));
  assign w_runLast  = (r_runCnt == (r_runLen - CNT_WIDTH'(1)));

  // State register. Reset is synchronous and overrides everything else,
  // even in the middle of a job.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and output decode. Every output comes only from the
  // registered state, so there is no combinational path from any input to
  // any output. In the active phases, abort is checked first. As a result,
  // an abort that arrives on the final LOAD or RUN cycle still wins over the
  // normal phase advance.
  always_comb begin
    w_nextState    = r_state;
    cmd_ready_o    = 1'b0;
    busy_o         = 1'b1;
    ctl_rst_o      = 1'b0;
    ctl_load_o     = 1'b0;
    ctl_ready_o    = 1'b0;
    ctl_start_op_o = 1'b0;
    wgt_rd_en_o    = 1'b0;
    done_o         = 1'b0;
    aborted_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          w_nextState = S_CLR;
        end
      end
      S_CLR: begin
        ctl_rst_o   = 1'b1;
        w_nextState = abort_i ? S_ABT : S_LOAD;
      end
      S_LOAD: begin
        ctl_load_o  = 1'b1;
        wgt_rd_en_o = 1'b1;
        if (abort_i) begin
          w_nextState = S_ABT;
        end else if (w_loadLast) begin
          w_nextState = S_ARM;
        end
      end
      S_ARM: begin
        ctl_ready_o = 1'b1;
        w_nextState = abort_i ? S_ABT : S_RUN;
      end
      S_RUN: begin
        ctl_start_op_o = 1'b1;
        if (abort_i) begin
          w_nextState = S_ABT;
        end else if (w_runLast) begin
          w_nextState = S_FIN;
        end
      end
      S_FIN: begin
        ctl_rst_o   = 1'b1;
        done_o      = 1'b1;
        w_nextState = S_IDLE;
      end
      S_ABT: begin
        ctl_rst_o   = 1'b1;
        aborted_o   = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Job datapath. On accept, the command fields are latched, and zero
  // lengths are stored as one. The fields then hold until the next accept.
  // The weight address advances only while LOAD continues, and it returns to
  // zero on any exit from LOAD. The run counter clears on accept and
  // advances only while RUN continues. It is left alone otherwise, so after
  // FIN or an abort it keeps showing the last value it reached.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_loadLen   <= '0;
      r_runLen    <= '0;
      r_addr      <= '0;
      r_runCnt    <= '0;
      r_columnNum <= '0;
      r_fSel      <= '0;
      r_enAdder1  <= 1'b0;
      r_enAdder2  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_columnNum <= cmd_column_num_i;
        r_fSel      <= cmd_f_sel_i;
        r_enAdder1  <= cmd_en_adder_1_i;
        r_enAdder2  <= cmd_en_adder_2_i;
        r_loadLen   <= (cmd_load_cycles_i == '0) ? CNT_WIDTH'(1) : cmd_load_cycles_i;
        r_runLen    <= (cmd_run_cycles_i == '0) ? CNT_WIDTH'(1) : cmd_run_cycles_i;
        r_runCnt    <= '0;
      end else if ((r_state == S_RUN) && (w_nextState == S_RUN)) begin
        r_runCnt <= r_runCnt + CNT_WIDTH'(1);
      end

      if ((r_state == S_LOAD) && (w_nextState == S_LOAD)) begin
        r_addr <= r_addr + CNT_WIDTH'(1);
      end else begin
        r_addr <= '0;
      end
    end
  end

  // The latched fields and counters are presented directly to the outputs.
  assign column_num_o  = r_columnNum;
  assign f_sel_o       = r_fSel;
  assign en_adder_1_o  = r_enAdder1;
  assign en_adder_2_o  = r_enAdder2;
  assign wgt_rd_addr_o = r_addr;
  assign run_cnt_o     = r_runCnt;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_array_sequencer
//
// Scoreboard bench for pe_array_sequencer. For every job it issues, the
// driver works out the complete per-cycle output trace from the job's phase
// lengths. That trace runs CLR, L load cycles, ARM, R run cycles and then
// FIN or ABT, followed by the first idle cycle. The driver queues the trace.
// A separate monitor pops one record per cycle and compares it with the DUT.
// When nothing is queued, the monitor expects the idle outputs that the
// model holds. Any busy cycle that the model did not predict is a failure.
// ---------------------------------------------------------------------------
module tb_pe_array_sequencer;

  localparam int CW = 16;

  typedef struct packed {
    logic          ctlRst;
    logic          ctlLoad;
    logic          ctlReady;
    logic          ctlStart;
    logic          rdEn;
    logic [CW-1:0] addr;
    logic [CW-1:0] runCnt;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          cmdReady;
    logic [1:0]    col;
    logic [1:0]    sel;
    logic          a1;
    logic          a2;
  } obsT;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [1:0]    cmd_column_num_i = '0;
  logic [1:0]    cmd_f_sel_i = '0;
  logic          cmd_en_adder_1_i = 1'b0;
  logic          cmd_en_adder_2_i = 1'b0;
  logic [CW-1:0] cmd_load_cycles_i = '0;
  logic [CW-1:0] cmd_run_cycles_i = '0;
  logic          abort_i = 1'b0;
  logic          ctl_rst_o;
  logic          ctl_load_o;
  logic          ctl_ready_o;
  logic          ctl_start_op_o;
  logic [1:0]    column_num_o;
  logic [1:0]    f_sel_o;
  logic          en_adder_1_o;
  logic          en_adder_2_o;
  logic          wgt_rd_en_o;
  logic [CW-1:0] wgt_rd_addr_o;
  logic [CW-1:0] run_cnt_o;
  logic          busy_o;
  logic          done_o;
  logic          aborted_o;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleNum = 0;

  obsT expQ[$];

  // Idle-state view held by the model: latched fields and final run count
  logic [1:0]    mCol = '0;
  logic [1:0]    mSel = '0;
  logic          mA1 = 1'b0;
  logic          mA2 = 1'b0;
  logic [CW-1:0] mRunCnt = '0;

  pe_array_sequencer #(.N(3), .NUM_COL_WIDTH(2), .SEL_WIDTH(2), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_column_num_i(cmd_column_num_i),
    .cmd_f_sel_i(cmd_f_sel_i),
    .cmd_en_adder_1_i(cmd_en_adder_1_i),
    .cmd_en_adder_2_i(cmd_en_adder_2_i),
    .cmd_load_cycles_i(cmd_load_cycles_i),
    .cmd_run_cycles_i(cmd_run_cycles_i),
    .abort_i(abort_i),
    .ctl_rst_o(ctl_rst_o),
    .ctl_load_o(ctl_load_o),
    .ctl_ready_o(ctl_ready_o),
    .ctl_start_op_o(ctl_start_op_o),
    .column_num_o(column_num_o),
    .f_sel_o(f_sel_o),
    .en_adder_1_o(en_adder_1_o),
    .en_adder_2_o(en_adder_2_o),
    .wgt_rd_en_o(wgt_rd_en_o),
    .wgt_rd_addr_o(wgt_rd_addr_o),
    .run_cnt_o(run_cnt_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .aborted_o(aborted_o)
  );

  // Free-running clock with a 10-unit period
  always #5 clk_i = ~clk_i;

  // Idle outputs: ready for a command, nothing driven, and fields held
  function automatic obsT idleRec();
    obsT r;
    r          = '0;
    r.cmdReady = 1'b1;
    r.runCnt   = mRunCnt;
    r.col      = mCol;
    r.sel      = mSel;
    r.a1       = mA1;
    r.a2       = mA2;
    return r;
  endfunction

  // Expected outputs on cycle j after accept, for a job of le load and re run
  // cycles, derived from where j falls in the phase ranges
  function automatic obsT jobRec(int j, int le, int re);
    obsT r;
    r      = '0;
    r.busy = 1'b1;
    r.col  = mCol;
    r.sel  = mSel;
    r.a1   = mA1;
    r.a2   = mA2;
    if (j == 0) begin
      r.ctlRst = 1'b1;
    end else if (j <= le) begin
      r.ctlLoad = 1'b1;
      r.rdEn    = 1'b1;
      r.addr    = CW'(j - 1);
    end else if (j == le + 1) begin
      r.ctlReady = 1'b1;
    end else if (j <= le + re + 1) begin
      r.ctlStart = 1'b1;
      r.runCnt   = CW'(j - le - 2);
    end else begin
      r.ctlRst = 1'b1;
      r.done   = 1'b1;
      r.runCnt = CW'(re - 1);
    end
    return r;
  endfunction

  // Compare one cycle of DUT outputs against the expected record
  task automatic checkOutput(input obsT expRec);
    obsT got;
    got.ctlRst   = ctl_rst_o;
    got.ctlLoad  = ctl_load_o;
    got.ctlReady = ctl_ready_o;
    got.ctlStart = ctl_start_op_o;
    got.rdEn     = wgt_rd_en_o;
    got.addr     = wgt_rd_addr_o;
    got.runCnt   = run_cnt_o;
    got.busy     = busy_o;
    got.done     = done_o;
    got.aborted  = aborted_o;
    got.cmdReady = cmd_ready_o;
    got.col      = column_num_o;
    got.sel      = f_sel_o;
    got.a1       = en_adder_1_o;
    got.a2       = en_adder_2_o;
    testsRun++;
    if (got !== expRec) begin
      testsFailed++;
      $display("[TB] FAIL outputs cycle %0d: got %h expected %h (rst/ld/rdy/st/en/addr/cnt/busy/done/abt/cready/col/sel/a1/a2)",
               cycleNum, got, expRec);
    end
  endtask

  // Monitor: each cycle, just after the rising edge, take the next predicted
  // record or the idle view, and compare it with what the DUT shows
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      cycleNum++;
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end else begin
        checkOutput(idleRec());
      end
    end
  end

  // Issue one job. The optional abort or reset is applied during job cycle
  // abortIdx or rstIdx (-1 for none). With holdValid set, cmd_valid_i stays
  // high after the accept.
  task automatic applyStimulus(input int lenL, input int lenR, input int col, input int sel,
                               input int a1, input int a2, input int abortIdx,
                               input int rstIdx, input bit holdValid);
    int le;
    int re;
    int lastIdx;
    int guard;
    obsT r;
    guard = 0;
    while (expQ.size() != 0 && guard < 5000) begin
      @(negedge clk_i);
      guard++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain timeout: %0d records left, required 0", expQ.size());
      expQ.delete();
    end
    le = (lenL == 0) ? 1 : lenL;
    re = (lenR == 0) ? 1 : lenR;
    cmd_column_num_i  = 2'(col);
    cmd_f_sel_i       = 2'(sel);
    cmd_en_adder_1_i  = a1[0];
    cmd_en_adder_2_i  = a2[0];
    cmd_load_cycles_i = CW'(lenL);
    cmd_run_cycles_i  = CW'(lenR);
    cmd_valid_i       = 1'b1;
    mCol = 2'(col);
    mSel = 2'(sel);
    mA1  = a1[0];
    mA2  = a2[0];
    if (abortIdx >= 0) begin
      for (int j = 0; j <= abortIdx; j++) begin
        r = jobRec(j, le, re);
        expQ.push_back(r);
      end
      mRunCnt   = r.runCnt;
      r         = '0;
      r.busy    = 1'b1;
      r.ctlRst  = 1'b1;
      r.aborted = 1'b1;
      r.runCnt  = mRunCnt;
      r.col     = mCol;
      r.sel     = mSel;
      r.a1      = mA1;
      r.a2      = mA2;
      expQ.push_back(r);
      lastIdx = abortIdx + 1;
    end else begin
      for (int j = 0; j <= le + re + 2; j++) begin
        expQ.push_back(jobRec(j, le, re));
      end
      mRunCnt = CW'(re - 1);
      lastIdx = le + re + 2;
    end
    expQ.push_back(idleRec());
    @(posedge clk_i);
    for (int k = 0; k <= lastIdx; k++) begin
      @(negedge clk_i);
      if (k == 0 && !holdValid) cmd_valid_i = 1'b0;
      abort_i = (k == abortIdx);
      if (k == rstIdx) begin
        rst_i = 1'b1;
        expQ.delete();
        mCol    = '0;
        mSel    = '0;
        mA1     = 1'b0;
        mA2     = 1'b0;
        mRunCnt = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        break;
      end
    end
    abort_i = 1'b0;
  endtask

  // Directed cases first, then randomized jobs, then drain and summarize
  initial begin
    int lenL;
    int lenR;
    int ab;
    int guard;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    applyStimulus(3, 4, 2, 1, 1, 0, -1, -1, 1'b0);
    applyStimulus(0, 0, 1, 2, 0, 1, -1, -1, 1'b0);
    applyStimulus(2, 5, 3, 0, 1, 1, 5, -1, 1'b0);
    applyStimulus(1, 1, 1, 1, 0, 0, -1, -1, 1'b1);
    applyStimulus(1, 1, 2, 2, 1, 0, -1, -1, 1'b0);
    applyStimulus(4, 2, 3, 3, 1, 1, -1, 2, 1'b0);
    applyStimulus(2, 3, 1, 0, 0, 1, -1, -1, 1'b0);

    repeat (2) @(negedge clk_i);
    abort_i = 1'b1;
    repeat (2) @(negedge clk_i);
    abort_i = 1'b0;

    applyStimulus(3, 2, 2, 1, 1, 1, 3, -1, 1'b0);
    applyStimulus(2, 2, 0, 3, 0, 0, 0, -1, 1'b0);
    applyStimulus(600, 700, 1, 2, 1, 0, -1, -1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      lenL = int'($urandom_range(0, 10));
      lenR = int'($urandom_range(0, 10));
      ab   = -1;
      if ($urandom_range(0, 3) == 0) begin
        ab = int'($urandom_range(0, ((lenL == 0) ? 1 : lenL) + ((lenR == 0) ? 1 : lenR) + 1));
      end
      applyStimulus(lenL, lenR, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), ab, -1,
                    ($urandom_range(0, 4) == 0));
    end

    cmd_valid_i = 1'b0;
    guard = 0;
    while (expQ.size() != 0 && guard < 5000) begin
      @(negedge clk_i);
      guard++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL final drain: %0d records left, required 0", expQ.size());
    end
    repeat (3) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
